param_rob: RTL and testbench

PARAM_ROB -- requirements
Module: param_rob

---
 rtl/param_rob.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_param_rob.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_rob.sv
// param_rob: parameterised reorder buffer.
// Entries are allocated in program order at the tail, marked ready by the
// CDB (ALU/branch) or load writeback ports, and retired in order from the
// head, at most one per cycle. Retirement drives a register write, a store
// release, a predictor update and, on a mispredict or jalr, a flush that
// empties the buffer on the same edge.
//
// Ports
//   clk, rst, ena                      clock, sync active-high reset, enable
//   in_alloc_*                         allocation request and entry payload
//   out_alloc_tag                      tag of the next allocation (0 = full)
//   out_full, out_empty, out_count     occupancy status
//   in_cdb_*                           ALU/branch writeback (value, outcome)
//   in_ls_*                            load writeback
//   in_q_tag1/2, out_q_ready/value1/2  combinational operand lookup
//   out_reg_*                          register commit
//   out_store_tag                      committed store tag (0 = none)
//   out_bp_*                           branch predictor update
//   out_flush, out_flush_pc            mispredict redirect
module param_rob #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_alloc_valid,
  input  logic [1:0]        in_alloc_kind,
  input  logic [REG_W-1:0]  in_alloc_dest,
  input  logic [DATA_W-1:0] in_alloc_pc,
  input  logic              in_alloc_pred_taken,
  output logic [TAG_W-1:0]  out_alloc_tag,
  output logic              out_full,
  output logic              out_empty,
  output logic [TAG_W:0]    out_count,
  input  logic [TAG_W-1:0]  in_cdb_tag,
  input  logic [DATA_W-1:0] in_cdb_value,
  input  logic              in_cdb_taken,
  input  logic [DATA_W-1:0] in_cdb_target,
  input  logic [TAG_W-1:0]  in_ls_tag,
  input  logic [DATA_W-1:0] in_ls_value,
  input  logic [TAG_W-1:0]  in_q_tag1,
  input  logic [TAG_W-1:0]  in_q_tag2,
  output logic              out_q_ready1,
  output logic [DATA_W-1:0] out_q_value1,
  output logic              out_q_ready2,
  output logic [DATA_W-1:0] out_q_value2,
  output logic              out_reg_en,
  output logic [REG_W-1:0]  out_reg_dest,
  output logic [TAG_W-1:0]  out_reg_tag,
  output logic [DATA_W-1:0] out_reg_value,
  output logic [TAG_W-1:0]  out_store_tag,
  output logic              out_bp_en,
  output logic [DATA_W-1:0] out_bp_pc,
  output logic              out_bp_taken,
  output logic              out_flush,
  output logic [DATA_W-1:0] out_flush_pc
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = TAG_W + 1;

  localparam logic [1:0] KIND_REG    = 2'd0;
  localparam logic [1:0] KIND_STORE  = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;
  localparam logic [1:0] KIND_JALR   = 2'd3;

  typedef struct packed {
    logic [1:0]        kind;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] pc;
    logic              pred;
    logic [DATA_W-1:0] value;
    logic              taken;
    logic [DATA_W-1:0] target;
  } entry_t;

  // Tags are 1-based; slot index is tag-1.
  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= TAG_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
    return (t == TAG_W'(DEPTH)) ? TAG_W'(1) : t + TAG_W'(1);
  endfunction

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] rdy;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic [IDX_W-1:0] head_idx, tail_idx, cdb_idx, ls_idx, q1_idx, q2_idx;
  logic             cdb_hit, ls_hit;
  logic             do_commit, do_alloc, do_flush;
  entry_t           head_ent, new_ent;

  assign out_full      = (out_count == CNT_W'(DEPTH));
  assign out_empty     = (out_count == '0);
  assign out_alloc_tag = out_full ? '0 : tail;

  assign head_idx = idx_of(head);
  assign tail_idx = idx_of(tail);
  assign cdb_idx  = idx_of(in_cdb_tag);
  assign ls_idx   = idx_of(in_ls_tag);
  assign q1_idx   = idx_of(in_q_tag1);
  assign q2_idx   = idx_of(in_q_tag2);
  assign head_ent = ent[head_idx];

  // Writebacks only land on occupied entries.
  assign cdb_hit = ena && tag_ok(in_cdb_tag) && occ[cdb_idx];
  assign ls_hit  = ena && tag_ok(in_ls_tag)  && occ[ls_idx];

  assign do_commit = ena && !out_empty && rdy[head_idx];
  assign do_alloc  = ena && in_alloc_valid && !out_full;

  // A committing jalr always redirects; a branch only when mispredicted.
  always_comb begin
    do_flush = 1'b0;
    if (do_commit) begin
      if (head_ent.kind == KIND_JALR) begin
        do_flush = 1'b1;
      end else if (head_ent.kind == KIND_BRANCH) begin
        do_flush = (head_ent.taken != head_ent.pred);
      end
    end
  end

  // Fresh entry: outcome fields zeroed so a stale slot never leaks through.
  always_comb begin
    new_ent        = '0;
    new_ent.kind   = in_alloc_kind;
    new_ent.dest   = in_alloc_dest;
    new_ent.pc     = in_alloc_pc;
    new_ent.pred   = in_alloc_pred_taken;
  end

  // Operand lookups: same-cycle writeback bypass (load beats CDB), else storage.
  always_comb begin
    out_q_ready1 = 1'b0;
    out_q_value1 = '0;
    if (tag_ok(in_q_tag1)) begin
      if (ls_hit && (in_ls_tag == in_q_tag1)) begin
        out_q_ready1 = 1'b1;
        out_q_value1 = in_ls_value;
      end else if (cdb_hit && (in_cdb_tag == in_q_tag1)) begin
        out_q_ready1 = 1'b1;
        out_q_value1 = in_cdb_value;
      end else if (rdy[q1_idx]) begin
        out_q_ready1 = 1'b1;
        out_q_value1 = ent[q1_idx].value;
      end
    end
  end

  always_comb begin
    out_q_ready2 = 1'b0;
    out_q_value2 = '0;
    if (tag_ok(in_q_tag2)) begin
      if (ls_hit && (in_ls_tag == in_q_tag2)) begin
        out_q_ready2 = 1'b1;
        out_q_value2 = in_ls_value;
      end else if (cdb_hit && (in_cdb_tag == in_q_tag2)) begin
        out_q_ready2 = 1'b1;
        out_q_value2 = in_cdb_value;
      end else if (rdy[q2_idx]) begin
        out_q_ready2 = 1'b1;
        out_q_value2 = ent[q2_idx].value;
      end
    end
  end

  // Entry storage; payload needs no reset since ready gates every read.
  always_ff @(posedge clk) begin
    if (!rst && ena) begin
      if (cdb_hit) begin
        ent[cdb_idx].value  <= in_cdb_value;
        ent[cdb_idx].taken  <= in_cdb_taken;
        ent[cdb_idx].target <= in_cdb_target;
      end
      // Later assignment wins when both ports hit the same entry.
      if (ls_hit) begin
        ent[ls_idx].value <= in_ls_value;
      end
      if (do_alloc && !do_flush) begin
        ent[tail_idx] <= new_ent;
      end
    end
  end

  // Pointers, occupancy and registered commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= TAG_W'(1);
      tail          <= TAG_W'(1);
      out_count     <= '0;
      occ           <= '0;
      rdy           <= '0;
      out_reg_en    <= 1'b0;
      out_reg_dest  <= '0;
      out_reg_tag   <= '0;
      out_reg_value <= '0;
      out_store_tag <= '0;
      out_bp_en     <= 1'b0;
      out_bp_pc     <= '0;
      out_bp_taken  <= 1'b0;
      out_flush     <= 1'b0;
      out_flush_pc  <= '0;
    end else begin
      out_reg_en    <= 1'b0;
      out_store_tag <= '0;
      out_bp_en     <= 1'b0;
      out_flush     <= 1'b0;
      if (ena) begin
        if (cdb_hit) rdy[cdb_idx] <= 1'b1;
        if (ls_hit)  rdy[ls_idx]  <= 1'b1;

        if (do_commit) begin
          occ[head_idx] <= 1'b0;
          rdy[head_idx] <= 1'b0;
          head          <= tag_inc(head);
          case (head_ent.kind)
            KIND_REG: begin
              out_reg_en    <= 1'b1;
              out_reg_dest  <= head_ent.dest;
              out_reg_tag   <= head;
              out_reg_value <= head_ent.value;
            end
            KIND_STORE: begin
              out_store_tag <= head;
            end
            KIND_BRANCH: begin
              out_bp_en    <= 1'b1;
              out_bp_pc    <= head_ent.pc;
              out_bp_taken <= head_ent.taken;
              if (head_ent.taken != head_ent.pred) begin
                out_flush    <= 1'b1;
                out_flush_pc <= head_ent.taken ? head_ent.target
                                               : head_ent.pc + DATA_W'(4);
              end
            end
            default: begin
              out_reg_en    <= 1'b1;
              out_reg_dest  <= head_ent.dest;
              out_reg_tag   <= head;
              out_reg_value <= head_ent.value;
              out_bp_en     <= 1'b1;
              out_bp_pc     <= head_ent.pc;
              out_bp_taken  <= 1'b1;
              out_flush     <= 1'b1;
              out_flush_pc  <= head_ent.target;
            end
          endcase
        end

        if (do_alloc) begin
          occ[tail_idx] <= 1'b1;
          rdy[tail_idx] <= 1'b0;
          tail          <= tag_inc(tail);
        end

        out_count <= out_count + CNT_W'(do_alloc) - CNT_W'(do_commit);

        // Redirect overrides everything else that happened this edge.
        if (do_flush) begin
          occ       <= '0;
          rdy       <= '0;
          head      <= TAG_W'(1);
          tail      <= TAG_W'(1);
          out_count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_rob.sv
`timescale 1ns/1ps
module tb_param_rob;
  localparam int DEPTH = 4, TAG_W = 3, DATA_W = 32, REG_W = 5;

  logic clk = 1'b0;
  logic rst, ena;
  logic in_alloc_valid, in_alloc_pred_taken;
  logic [1:0] in_alloc_kind;
  logic [REG_W-1:0] in_alloc_dest;
  logic [DATA_W-1:0] in_alloc_pc;
  logic [TAG_W-1:0] out_alloc_tag;
  logic out_full, out_empty;
  logic [TAG_W:0] out_count;
  logic [TAG_W-1:0] in_cdb_tag, in_ls_tag, in_q_tag1, in_q_tag2;
  logic [DATA_W-1:0] in_cdb_value, in_cdb_target, in_ls_value;
  logic in_cdb_taken;
  logic out_q_ready1, out_q_ready2;
  logic [DATA_W-1:0] out_q_value1, out_q_value2;
  logic out_reg_en;
  logic [REG_W-1:0] out_reg_dest;
  logic [TAG_W-1:0] out_reg_tag, out_store_tag;
  logic [DATA_W-1:0] out_reg_value, out_bp_pc, out_flush_pc;
  logic out_bp_en, out_bp_taken, out_flush;

  int n_vec = 0;
  int n_err = 0;

  param_rob #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_alloc_valid(in_alloc_valid), .in_alloc_kind(in_alloc_kind),
    .in_alloc_dest(in_alloc_dest), .in_alloc_pc(in_alloc_pc),
    .in_alloc_pred_taken(in_alloc_pred_taken),
    .out_alloc_tag(out_alloc_tag), .out_full(out_full), .out_empty(out_empty),
    .out_count(out_count),
    .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_taken(in_cdb_taken), .in_cdb_target(in_cdb_target),
    .in_ls_tag(in_ls_tag), .in_ls_value(in_ls_value),
    .in_q_tag1(in_q_tag1), .in_q_tag2(in_q_tag2),
    .out_q_ready1(out_q_ready1), .out_q_value1(out_q_value1),
    .out_q_ready2(out_q_ready2), .out_q_value2(out_q_value2),
    .out_reg_en(out_reg_en), .out_reg_dest(out_reg_dest),
    .out_reg_tag(out_reg_tag), .out_reg_value(out_reg_value),
    .out_store_tag(out_store_tag),
    .out_bp_en(out_bp_en), .out_bp_pc(out_bp_pc), .out_bp_taken(out_bp_taken),
    .out_flush(out_flush), .out_flush_pc(out_flush_pc)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    int                tag;
    logic [1:0]        kind;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] pc;
    logic              pred;
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic              taken;
    logic [DATA_W-1:0] tgt;
  } ment_t;

  ment_t mq[$];
  int m_tail = 1;
  logic e_reg_en = 0, e_bp_en = 0, e_bp_taken = 0, e_flush = 0;
  logic [REG_W-1:0] e_reg_dest = '0;
  logic [TAG_W-1:0] e_reg_tag = '0, e_store_tag = '0;
  logic [DATA_W-1:0] e_reg_value = '0, e_bp_pc = '0, e_flush_pc = '0;

  function automatic logic [DATA_W:0] model_query(input logic [TAG_W-1:0] q);
    int k;
    k = -1;
    if (q == '0) return '0;
    foreach (mq[i]) if (mq[i].tag == int'(q)) k = i;
    if (k < 0) return '0;
    if (ena && in_ls_tag == q) return {1'b1, in_ls_value};
    if (ena && in_cdb_tag == q) return {1'b1, in_cdb_value};
    if (mq[k].rdy) return {1'b1, mq[k].val};
    return '0;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    ment_t h, t;
    bit commit, alloc, fl;
    if (rst) begin
      mq.delete(); m_tail = 1;
      e_reg_en = 0; e_reg_dest = '0; e_reg_tag = '0; e_reg_value = '0; e_store_tag = '0;
      e_bp_en = 0; e_bp_pc = '0; e_bp_taken = 0; e_flush = 0; e_flush_pc = '0;
      return;
    end
    e_reg_en = 0; e_store_tag = '0; e_bp_en = 0; e_flush = 0;
    if (!ena) return;
    commit = (mq.size() > 0) && mq[0].rdy;
    alloc = in_alloc_valid && (mq.size() < DEPTH);
    fl = 0;
    if (commit) h = mq[0];
    foreach (mq[i]) begin
      t = mq[i];
      if (in_cdb_tag != '0 && t.tag == int'(in_cdb_tag)) begin
        t.rdy = 1; t.val = in_cdb_value; t.taken = in_cdb_taken; t.tgt = in_cdb_target;
      end
      if (in_ls_tag != '0 && t.tag == int'(in_ls_tag)) begin
        t.rdy = 1; t.val = in_ls_value;
      end
      mq[i] = t;
    end
    if (commit) begin
      void'(mq.pop_front());
      case (h.kind)
        2'd0: begin e_reg_en = 1; e_reg_dest = h.dest; e_reg_tag = TAG_W'(h.tag); e_reg_value = h.val; end
        2'd1: e_store_tag = TAG_W'(h.tag);
        2'd2: begin
          e_bp_en = 1; e_bp_pc = h.pc; e_bp_taken = h.taken;
          if (h.taken != h.pred) begin
            e_flush = 1; fl = 1;
            e_flush_pc = h.taken ? h.tgt : h.pc + 32'd4;
          end
        end
        default: begin
          e_reg_en = 1; e_reg_dest = h.dest; e_reg_tag = TAG_W'(h.tag); e_reg_value = h.val;
          e_bp_en = 1; e_bp_pc = h.pc; e_bp_taken = 1;
          e_flush = 1; e_flush_pc = h.tgt; fl = 1;
        end
      endcase
    end
    if (fl) begin
      mq.delete(); m_tail = 1;
    end else if (alloc) begin
      t = '{tag: m_tail, kind: in_alloc_kind, dest: in_alloc_dest, pc: in_alloc_pc,
            pred: in_alloc_pred_taken, rdy: 1'b0, val: '0, taken: 1'b0, tgt: '0};
      mq.push_back(t);
      m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1; in_alloc_valid = 0; in_alloc_kind = '0; in_alloc_dest = '0;
    in_alloc_pc = '0; in_alloc_pred_taken = 0;
    in_cdb_tag = '0; in_cdb_value = '0; in_cdb_taken = 0; in_cdb_target = '0;
    in_ls_tag = '0; in_ls_value = '0; in_q_tag1 = '0; in_q_tag2 = '0;
  endtask

  task automatic set_alloc(input logic [1:0] k, input logic [REG_W-1:0] d,
                           input logic [DATA_W-1:0] pc, input logic pr);
    in_alloc_valid = 1; in_alloc_kind = k; in_alloc_dest = d;
    in_alloc_pc = pc; in_alloc_pred_taken = pr;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; set_alloc(2'd0, 5'd1, 32'h10, 0); tick(); tick(); rst = 0; idle();
    n_vec++; if (out_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", out_count); end
    n_vec++; if ({out_empty, out_full} !== 2'b10) begin n_err++; $display("FAIL reset_empty_full got %b want 10", {out_empty, out_full}); end
    n_vec++; if (out_alloc_tag !== 3'd1) begin n_err++; $display("FAIL reset_alloc_tag got %0d want 1", out_alloc_tag); end
    n_vec++; if ({out_reg_en, out_reg_dest, out_reg_tag, out_reg_value, out_store_tag} !== '0) begin n_err++; $display("FAIL reset_reg_outputs not zero"); end
    n_vec++; if ({out_bp_en, out_bp_pc, out_bp_taken, out_flush, out_flush_pc} !== '0) begin n_err++; $display("FAIL reset_bp_flush_outputs not zero"); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      idle(); set_alloc(2'd0, REG_W'(i), 32'h1000 + 32'(4 * i), 0); #1;
      n_vec++; if (out_alloc_tag !== TAG_W'(i)) begin n_err++; $display("FAIL fill_tag got %0d want %0d", out_alloc_tag, i); end
      tick();
    end
    idle();
    n_vec++; if ({out_full, out_alloc_tag} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL fill_full got full=%b tag=%0d want full=1 tag=0", out_full, out_alloc_tag); end
    set_alloc(2'd0, 5'd9, 32'h2000, 0); tick(); idle();
    n_vec++; if (out_count !== 4'd4) begin n_err++; $display("FAIL fill_overflow_count got %0d want 4", out_count); end
  endtask

  task automatic test_order();
    idle(); in_cdb_tag = 3'd2; in_cdb_value = 32'h22; tick();
    n_vec++; if (out_reg_en !== 1'b0) begin n_err++; $display("FAIL order_no_early_commit got %b want 0", out_reg_en); end
    idle(); in_cdb_tag = 3'd1; in_cdb_value = 32'h11; tick();
    n_vec++; if (out_reg_en !== 1'b0) begin n_err++; $display("FAIL order_commit_latency got %b want 0", out_reg_en); end
    idle(); tick();
    n_vec++; if ({out_reg_en, out_reg_dest, out_reg_tag, out_reg_value} !== {1'b1, 5'd1, 3'd1, 32'h11}) begin n_err++; $display("FAIL order_first got en=%b tag=%0d val=%h want en=1 tag=1 val=11", out_reg_en, out_reg_tag, out_reg_value); end
    tick();
    n_vec++; if ({out_reg_en, out_reg_dest, out_reg_tag, out_reg_value} !== {1'b1, 5'd2, 3'd2, 32'h22}) begin n_err++; $display("FAIL order_second got en=%b tag=%0d val=%h want en=1 tag=2 val=22", out_reg_en, out_reg_tag, out_reg_value); end
    tick();
    n_vec++; if ({out_reg_en, out_reg_tag, out_reg_value, out_count} !== {1'b0, 3'd2, 32'h22, 4'd2}) begin n_err++; $display("FAIL order_hold got en=%b tag=%0d val=%h cnt=%0d want en=0 tag=2 val=22 cnt=2", out_reg_en, out_reg_tag, out_reg_value, out_count); end
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 1; i <= 3; i++) begin idle(); set_alloc(2'd0, REG_W'(i), 32'(i), 0); tick(); end
    idle(); in_ls_tag = 3'd3; in_ls_value = 32'hAB; in_q_tag1 = 3'd3; in_q_tag2 = 3'd0; #1;
    n_vec++; if ({out_q_ready1, out_q_value1} !== {1'b1, 32'hAB}) begin n_err++; $display("FAIL query_bypass got r=%b v=%h want r=1 v=ab", out_q_ready1, out_q_value1); end
    n_vec++; if ({out_q_ready2, out_q_value2} !== 33'd0) begin n_err++; $display("FAIL query_tag0 got r=%b v=%h want 0", out_q_ready2, out_q_value2); end
    in_q_tag2 = 3'd2; #1;
    n_vec++; if (out_q_ready2 !== 1'b0) begin n_err++; $display("FAIL query_not_ready got %b want 0", out_q_ready2); end
    tick(); idle(); in_q_tag1 = 3'd3; in_cdb_tag = 3'd2; in_cdb_value = 32'hC0; in_ls_tag = 3'd2; in_ls_value = 32'hD0; in_q_tag2 = 3'd2; #1;
    n_vec++; if ({out_q_ready1, out_q_value1} !== {1'b1, 32'hAB}) begin n_err++; $display("FAIL query_stored got r=%b v=%h want r=1 v=ab", out_q_ready1, out_q_value1); end
    n_vec++; if ({out_q_ready2, out_q_value2} !== {1'b1, 32'hD0}) begin n_err++; $display("FAIL query_load_wins got r=%b v=%h want r=1 v=d0", out_q_ready2, out_q_value2); end
    tick(); idle(); in_q_tag2 = 3'd2; #1;
    n_vec++; if ({out_q_ready2, out_q_value2} !== {1'b1, 32'hD0}) begin n_err++; $display("FAIL query_load_wins_stored got r=%b v=%h want r=1 v=d0", out_q_ready2, out_q_value2); end
  endtask

  task automatic test_branch();
    do_reset();
    idle(); set_alloc(2'd2, 5'd0, 32'h100, 0); tick();
    idle(); set_alloc(2'd0, 5'd7, 32'h104, 0); tick();
    idle(); in_cdb_tag = 3'd1; in_cdb_taken = 1; in_cdb_target = 32'h200; tick();
    idle(); set_alloc(2'd0, 5'd3, 32'h108, 0); in_ls_tag = 3'd2; in_ls_value = 32'h5; tick();
    n_vec++; if ({out_flush, out_flush_pc, out_bp_en, out_bp_pc, out_bp_taken} !== {1'b1, 32'h200, 1'b1, 32'h100, 1'b1}) begin n_err++; $display("FAIL branch_flush got fl=%b pc=%h bp=%b bppc=%h tk=%b want 1 200 1 100 1", out_flush, out_flush_pc, out_bp_en, out_bp_pc, out_bp_taken); end
    n_vec++; if ({out_count, out_alloc_tag, out_empty} !== {4'd0, 3'd1, 1'b1}) begin n_err++; $display("FAIL branch_cleared got cnt=%0d tag=%0d empty=%b want 0 1 1", out_count, out_alloc_tag, out_empty); end
    idle(); tick();
    n_vec++; if ({out_flush, out_bp_en, out_flush_pc} !== {1'b0, 1'b0, 32'h200}) begin n_err++; $display("FAIL branch_pulse_clear got fl=%b bp=%b pc=%h want 0 0 200", out_flush, out_bp_en, out_flush_pc); end
  endtask

  task automatic test_kinds();
    do_reset();
    idle(); set_alloc(2'd1, 5'd0, 32'h200, 0); tick();
    idle(); set_alloc(2'd2, 5'd0, 32'h300, 0); tick();
    idle(); set_alloc(2'd3, 5'd9, 32'h400, 0); tick();
    idle(); in_ls_tag = 3'd1; in_cdb_tag = 3'd2; in_cdb_taken = 0; in_cdb_target = 32'h999; tick();
    idle(); in_cdb_tag = 3'd3; in_cdb_value = 32'h404; in_cdb_target = 32'h800; tick();
    n_vec++; if ({out_store_tag, out_reg_en, out_bp_en} !== {3'd1, 1'b0, 1'b0}) begin n_err++; $display("FAIL kind_store got st=%0d reg=%b bp=%b want 1 0 0", out_store_tag, out_reg_en, out_bp_en); end
    idle(); tick();
    n_vec++; if ({out_store_tag, out_bp_en, out_bp_pc, out_bp_taken, out_flush} !== {3'd0, 1'b1, 32'h300, 1'b0, 1'b0}) begin n_err++; $display("FAIL kind_branch_ok got st=%0d bp=%b pc=%h tk=%b fl=%b want 0 1 300 0 0", out_store_tag, out_bp_en, out_bp_pc, out_bp_taken, out_flush); end
    tick();
    n_vec++; if ({out_reg_en, out_reg_dest, out_reg_tag, out_reg_value} !== {1'b1, 5'd9, 3'd3, 32'h404}) begin n_err++; $display("FAIL kind_jalr_reg got en=%b d=%0d t=%0d v=%h want 1 9 3 404", out_reg_en, out_reg_dest, out_reg_tag, out_reg_value); end
    n_vec++; if ({out_flush, out_flush_pc, out_bp_en, out_bp_pc, out_bp_taken} !== {1'b1, 32'h800, 1'b1, 32'h400, 1'b1}) begin n_err++; $display("FAIL kind_jalr_flush got fl=%b pc=%h bp=%b bppc=%h tk=%b want 1 800 1 400 1", out_flush, out_flush_pc, out_bp_en, out_bp_pc, out_bp_taken); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 3; i++) begin idle(); set_alloc(2'd0, REG_W'(i), 32'(i), 0); tick(); end
    idle(); in_cdb_tag = 3'd1; in_ls_tag = 3'd2; tick();
    idle(); tick();
    n_vec++; if ({out_reg_en, out_reg_tag} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL wrap_c1 got en=%b tag=%0d want 1 1", out_reg_en, out_reg_tag); end
    tick();
    n_vec++; if ({out_reg_en, out_reg_tag, out_count} !== {1'b1, 3'd2, 4'd1}) begin n_err++; $display("FAIL wrap_c2 got en=%b tag=%0d cnt=%0d want 1 2 1", out_reg_en, out_reg_tag, out_count); end
    idle(); set_alloc(2'd0, 5'd4, 32'h4, 0); #1;
    n_vec++; if (out_alloc_tag !== 3'd4) begin n_err++; $display("FAIL wrap_tag4 got %0d want 4", out_alloc_tag); end
    tick(); set_alloc(2'd0, 5'd5, 32'h5, 0); #1;
    n_vec++; if (out_alloc_tag !== 3'd1) begin n_err++; $display("FAIL wrap_tag1 got %0d want 1", out_alloc_tag); end
    tick();
    idle(); in_cdb_tag = 3'd3; in_ls_tag = 3'd4; tick();
    idle(); in_cdb_tag = 3'd1; tick();
    n_vec++; if ({out_reg_en, out_reg_tag} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL wrap_c3 got en=%b tag=%0d want 1 3", out_reg_en, out_reg_tag); end
    idle(); tick();
    n_vec++; if ({out_reg_en, out_reg_tag} !== {1'b1, 3'd4}) begin n_err++; $display("FAIL wrap_c4 got en=%b tag=%0d want 1 4", out_reg_en, out_reg_tag); end
    tick();
    n_vec++; if ({out_reg_en, out_reg_tag, out_reg_dest, out_empty} !== {1'b1, 3'd1, 5'd5, 1'b1}) begin n_err++; $display("FAIL wrap_c1b got en=%b tag=%0d dest=%0d empty=%b want 1 1 5 1", out_reg_en, out_reg_tag, out_reg_dest, out_empty); end
  endtask

  task automatic test_ena();
    do_reset();
    for (int i = 1; i <= 2; i++) begin idle(); set_alloc(2'd0, REG_W'(i), 32'(i), 0); tick(); end
    idle(); in_cdb_tag = 3'd1; in_cdb_value = 32'h55; tick();
    idle(); ena = 0; set_alloc(2'd0, 5'd3, 32'h3, 0); in_cdb_tag = 3'd2; tick();
    n_vec++; if ({out_reg_en, out_count} !== {1'b0, 4'd2}) begin n_err++; $display("FAIL ena_freeze got en=%b cnt=%0d want 0 2", out_reg_en, out_count); end
    idle(); in_q_tag1 = 3'd2; #1;
    n_vec++; if (out_q_ready1 !== 1'b0) begin n_err++; $display("FAIL ena_no_writeback got %b want 0", out_q_ready1); end
    tick();
    n_vec++; if ({out_reg_en, out_reg_value} !== {1'b1, 32'h55}) begin n_err++; $display("FAIL ena_resume got en=%b v=%h want 1 55", out_reg_en, out_reg_value); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin idle(); set_alloc(2'd0, REG_W'(i), 32'(i), 0); tick(); end
    idle(); in_cdb_tag = 3'd1; in_cdb_value = 32'h77; tick();
    idle(); rst = 1; tick(); rst = 0;
    n_vec++; if ({out_reg_en, out_reg_value, out_count, out_empty, out_alloc_tag} !== {1'b0, 32'h0, 4'd0, 1'b1, 3'd1}) begin n_err++; $display("FAIL rst_mid got en=%b v=%h cnt=%0d empty=%b tag=%0d want 0 0 0 1 1", out_reg_en, out_reg_value, out_count, out_empty, out_alloc_tag); end
  endtask

  function automatic logic [TAG_W-1:0] pick_tag();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6 && mq.size() > 0) return TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
    if (r < 8) return '0;
    return TAG_W'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    int r;
    logic [DATA_W:0] eq;
    logic [8:0] est;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      ena = ($urandom_range(0, 9) != 0);
      in_alloc_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      in_alloc_kind = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      in_alloc_dest = REG_W'($urandom);
      in_alloc_pc = {$urandom_range(0, 65535), 2'b00};
      in_alloc_pred_taken = 1'($urandom);
      in_cdb_tag = pick_tag(); in_cdb_value = $urandom; in_cdb_taken = 1'($urandom);
      in_cdb_target = {$urandom_range(0, 65535), 2'b00};
      in_ls_tag = pick_tag(); in_ls_value = $urandom;
      in_q_tag1 = pick_tag(); in_q_tag2 = TAG_W'($urandom_range(0, 7));
      #1;
      eq = model_query(in_q_tag1);
      n_vec++; if ({out_q_ready1, out_q_value1} !== eq) begin n_err++; $display("FAIL rand_q1 cyc %0d got %h want %h", c, {out_q_ready1, out_q_value1}, eq); end
      eq = model_query(in_q_tag2);
      n_vec++; if ({out_q_ready2, out_q_value2} !== eq) begin n_err++; $display("FAIL rand_q2 cyc %0d got %h want %h", c, {out_q_ready2, out_q_value2}, eq); end
      est = {mq.size() == DEPTH, mq.size() == 0, 4'(mq.size()), (mq.size() == DEPTH) ? 3'd0 : 3'(m_tail)};
      n_vec++; if ({out_full, out_empty, out_count, out_alloc_tag} !== est) begin n_err++; $display("FAIL rand_status cyc %0d got %b want %b", c, {out_full, out_empty, out_count, out_alloc_tag}, est); end
      tick();
      n_vec++; if ({out_reg_en, out_reg_dest, out_reg_tag, out_reg_value} !== {e_reg_en, e_reg_dest, e_reg_tag, e_reg_value}) begin n_err++; $display("FAIL rand_reg cyc %0d got %h want %h", c, {out_reg_en, out_reg_dest, out_reg_tag, out_reg_value}, {e_reg_en, e_reg_dest, e_reg_tag, e_reg_value}); end
      n_vec++; if (out_store_tag !== e_store_tag) begin n_err++; $display("FAIL rand_store cyc %0d got %0d want %0d", c, out_store_tag, e_store_tag); end
      n_vec++; if ({out_bp_en, out_bp_pc, out_bp_taken} !== {e_bp_en, e_bp_pc, e_bp_taken}) begin n_err++; $display("FAIL rand_bp cyc %0d got %h want %h", c, {out_bp_en, out_bp_pc, out_bp_taken}, {e_bp_en, e_bp_pc, e_bp_taken}); end
      n_vec++; if ({out_flush, out_flush_pc} !== {e_flush, e_flush_pc}) begin n_err++; $display("FAIL rand_flush cyc %0d got %h want %h", c, {out_flush, out_flush_pc}, {e_flush, e_flush_pc}); end
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1; idle();
    test_reset();
    test_fill();
    test_order();
    test_query();
    test_branch();
    test_kinds();
    test_wrap();
    test_ena();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
